// File: rtl/tty_write_controller.sv
// Terminal write sequencer: turns an accepted byte stream into character-buffer
// cell writes and cursor moves, including row and full-screen blanking.
module tty_write_controller #(
    parameter int CHAR_HORZ_CNT  = 16,
    parameter int CHAR_VERT_CNT  = 2,
    parameter int CHAR_HORZ_W    = $clog2(CHAR_HORZ_CNT),
    parameter int CHAR_VERT_W    = $clog2(CHAR_VERT_CNT),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic [CHAR_HORZ_W-1:0] char_hpos,
    output logic [CHAR_VERT_W-1:0] char_vpos,
    output logic                   char_write_en,
    output logic [7:0]             char_symbol,
    output logic                   cursor_en,
    output logic [CHAR_HORZ_W-1:0] cursor_hpos,
    output logic [CHAR_VERT_W-1:0] cursor_vpos,
    output logic                   busy
);

    localparam logic [CHAR_HORZ_W-1:0] LAST_H = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
    localparam logic [CHAR_VERT_W-1:0] LAST_V = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
    localparam logic [7:0]             SPACE  = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_t;

    state_t                 state, state_next;
    logic [CHAR_HORZ_W-1:0] clr_h, clr_h_next;
    logic [CHAR_VERT_W-1:0] clr_v, clr_v_next;
    logic [CHAR_HORZ_W-1:0] cur_h_next;
    logic [CHAR_VERT_W-1:0] cur_v_next;
    logic                   wr_en_next;
    logic [CHAR_HORZ_W-1:0] wr_h_next;
    logic [CHAR_VERT_W-1:0] wr_v_next;
    logic [7:0]             sym_next;
    logic                   line_adv;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        clr_h_next = clr_h;
        clr_v_next = clr_v;
        cur_h_next = cursor_hpos;
        cur_v_next = cursor_vpos;
        wr_en_next = 1'b0;
        wr_h_next  = char_hpos;
        wr_v_next  = char_vpos;
        sym_next   = char_symbol;
        line_adv   = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_en_next = 1'b1;
                        wr_h_next  = cursor_hpos;
                        wr_v_next  = cursor_vpos;
                        sym_next   = in_data;
                        if (cursor_hpos == LAST_H) begin
                            cur_h_next = '0;
                            line_adv   = 1'b1;
                        end else begin
                            cur_h_next = cursor_hpos + 1'b1;
                        end
                    end else begin
                        case (in_data)
                            8'h0D: cur_h_next = '0;
                            8'h0A: begin
                                cur_h_next = '0;
                                line_adv   = 1'b1;
                            end
                            8'h08: begin
                                if (cursor_hpos != '0) begin
                                    cur_h_next = cursor_hpos - 1'b1;
                                    wr_en_next = 1'b1;
                                    wr_h_next  = cursor_hpos - 1'b1;
                                    wr_v_next  = cursor_vpos;
                                    sym_next   = SPACE;
                                end
                            end
                            8'h0C: begin
                                state_next = CLEAR_ALL;
                                cur_h_next = '0;
                                cur_v_next = '0;
                                clr_h_next = '0;
                                clr_v_next = '0;
                            end
                            default: ;
                        endcase
                    end
                    // Rows wrap instead of scrolling; the new row is blanked before accepting more input.
                    if (line_adv) begin
                        cur_v_next = (cursor_vpos == LAST_V) ? '0 : cursor_vpos + 1'b1;
                        clr_h_next = '0;
                        state_next = CLEAR_ROW;
                    end
                end
            end

            CLEAR_ROW: begin
                wr_en_next = 1'b1;
                wr_h_next  = clr_h;
                wr_v_next  = cursor_vpos;
                sym_next   = SPACE;
                if (clr_h == LAST_H) begin
                    clr_h_next = '0;
                    state_next = IDLE;
                end else begin
                    clr_h_next = clr_h + 1'b1;
                end
            end

            CLEAR_ALL: begin
                wr_en_next = 1'b1;
                wr_h_next  = clr_h;
                wr_v_next  = clr_v;
                sym_next   = SPACE;
                if (clr_h == LAST_H) begin
                    clr_h_next = '0;
                    if (clr_v == LAST_V) begin
                        clr_v_next = '0;
                        cur_h_next = '0;
                        cur_v_next = '0;
                        state_next = IDLE;
                    end else begin
                        clr_v_next = clr_v + 1'b1;
                    end
                end else begin
                    clr_h_next = clr_h + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= (CLEAR_ON_RESET != 0) ? CLEAR_ALL : IDLE;
            clr_h         <= '0;
            clr_v         <= '0;
            cursor_hpos   <= '0;
            cursor_vpos   <= '0;
            char_write_en <= 1'b0;
            char_hpos     <= '0;
            char_vpos     <= '0;
            char_symbol   <= '0;
            cursor_en     <= 1'b0;
        end else begin
            state         <= state_next;
            clr_h         <= clr_h_next;
            clr_v         <= clr_v_next;
            cursor_hpos   <= cur_h_next;
            cursor_vpos   <= cur_v_next;
            char_write_en <= wr_en_next;
            char_hpos     <= wr_h_next;
            char_vpos     <= wr_v_next;
            char_symbol   <= sym_next;
            cursor_en     <= (state_next == IDLE);
        end
    end

endmodule
